// File: rtl/light_countdown.sv
// light_countdown: per-direction two-digit remaining-seconds countdown driven by the controller lamps.
// Optional SEG7_EN adds registered 7-segment outputs (active-high, gfedcba).
module light_countdown_lane #(
  parameter int T_G = 40,
  parameter int T_Y = 5,
  parameter int T_L = 15,
  parameter int T_R = 55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       g,
  input  logic       y,
  input  logic       r,
  input  logic       l,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic       err_o
`ifdef SEG7_EN
  ,
  output logic [6:0] seg_t,
  output logic [6:0] seg_o
`endif
);
  typedef enum logic [2:0] {NONE, GRN, YEL, LFT, RED} phase_t;

  phase_t     phase, prev_phase;
  logic [6:0] cnt, load_val;
  logic       err;
  logic [3:0] bcd_t, bcd_o;
  logic       valid_nxt;

  always_comb begin
    phase    = NONE;
    load_val = '0;
    case ({g, y, l, r})
      4'b1000: begin phase = GRN; load_val = 7'(T_G); end
      4'b0100: begin phase = YEL; load_val = 7'(T_Y); end
      4'b0010: begin phase = LFT; load_val = 7'(T_L); end
      4'b0001: begin phase = RED; load_val = 7'(T_R); end
      default: phase = NONE;
    endcase
  end

  // A phase change loads even when a tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase <= NONE;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      prev_phase <= phase;
      if (phase == NONE) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (phase != prev_phase) begin
        cnt <= load_val;
        err <= 1'b0;
      end else if (tick) begin
        if (cnt > 7'd1) cnt <= cnt - 7'd1;
        else begin
          cnt <= '0;
          err <= 1'b1;
        end
      end
    end
  end

  assign bcd_t     = 4'(cnt / 7'd10);
  assign bcd_o     = 4'(cnt % 7'd10);
  assign valid_nxt = (prev_phase != NONE);

`ifdef SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction
`endif

  // Error flag is re-registered so it lines up with the digits it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens  <= '0;
      ones  <= '0;
      valid <= 1'b0;
      err_o <= 1'b0;
`ifdef SEG7_EN
      seg_t <= '0;
      seg_o <= '0;
`endif
    end else begin
      tens  <= bcd_t;
      ones  <= bcd_o;
      valid <= valid_nxt;
      err_o <= err;
`ifdef SEG7_EN
      seg_t <= (valid_nxt && bcd_t != 4'd0) ? seg7(bcd_t) : 7'b0;
      seg_o <= valid_nxt ? seg7(bcd_o) : 7'b0;
`endif
    end
  end
endmodule

module light_countdown #(
  parameter int T_G_EW = 40,
  parameter int T_G_NS = 30,
  parameter int T_Y    = 5,
  parameter int T_L    = 15,
  parameter int T_R_EW = 55,
  parameter int T_R_NS = 65
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] G,
  input  logic [1:0] Y,
  input  logic [1:0] R,
  input  logic [1:0] L,
  output logic [3:0] ew_tens,
  output logic [3:0] ew_ones,
  output logic [3:0] ns_tens,
  output logic [3:0] ns_ones,
  output logic       ew_valid,
  output logic       ns_valid,
  output logic       ew_err,
  output logic       ns_err
`ifdef SEG7_EN
  ,
  output logic [6:0] ew_seg_t,
  output logic [6:0] ew_seg_o,
  output logic [6:0] ns_seg_t,
  output logic [6:0] ns_seg_o
`endif
);
  localparam int NUM_LANES = 2;  // lane 1 = EW, lane 0 = NS

  logic [NUM_LANES-1:0][3:0] tens_v, ones_v;
  logic [NUM_LANES-1:0]      valid_v, err_v;
`ifdef SEG7_EN
  logic [NUM_LANES-1:0][6:0] seg_t_v, seg_o_v;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    light_countdown_lane #(
      .T_G (i == 1 ? T_G_EW : T_G_NS),
      .T_Y (T_Y),
      .T_L (T_L),
      .T_R (i == 1 ? T_R_EW : T_R_NS)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .g     (G[i]),
      .y     (Y[i]),
      .r     (R[i]),
      .l     (L[i]),
      .tens  (tens_v[i]),
      .ones  (ones_v[i]),
      .valid (valid_v[i]),
      .err_o (err_v[i])
`ifdef SEG7_EN
      ,
      .seg_t (seg_t_v[i]),
      .seg_o (seg_o_v[i])
`endif
    );
  end

  assign ew_tens  = tens_v[1];
  assign ew_ones  = ones_v[1];
  assign ew_valid = valid_v[1];
  assign ew_err   = err_v[1];
  assign ns_tens  = tens_v[0];
  assign ns_ones  = ones_v[0];
  assign ns_valid = valid_v[0];
  assign ns_err   = err_v[0];
`ifdef SEG7_EN
  assign ew_seg_t = seg_t_v[1];
  assign ew_seg_o = seg_o_v[1];
  assign ns_seg_t = seg_t_v[0];
  assign ns_seg_o = seg_o_v[0];
`endif
endmodule

// File: tb/tb_light_countdown.sv
// Bench for light_countdown: elapsed-ticks model checked every cycle, plus directed literal checks.
module tb_light_countdown;
  logic       clk = 1'b0;
  logic       rst, tick;
  logic [1:0] G, Y, R, L;
  logic [3:0] ew_tens, ew_ones, ns_tens, ns_ones;
  logic       ew_valid, ns_valid, ew_err, ns_err;
`ifdef SEG7_EN
  logic [6:0] ew_seg_t, ew_seg_o, ns_seg_t, ns_seg_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  light_countdown dut (
    .clk(clk), .rst(rst), .tick(tick), .G(G), .Y(Y), .R(R), .L(L),
    .ew_tens(ew_tens), .ew_ones(ew_ones), .ns_tens(ns_tens), .ns_ones(ns_ones),
    .ew_valid(ew_valid), .ns_valid(ns_valid), .ew_err(ew_err), .ns_err(ns_err)
`ifdef SEG7_EN
    , .ew_seg_t(ew_seg_t), .ew_seg_o(ew_seg_o), .ns_seg_t(ns_seg_t), .ns_seg_o(ns_seg_o)
`endif
  );

  always #5 clk = ~clk;

  // phases: 0 none, 1 green, 2 yellow, 3 left, 4 red; d=1 EW, d=0 NS
  function automatic int dur(input int d, input int p);
    case (p)
      1: return d ? 40 : 30;
      2: return 5;
      3: return 15;
      4: return d ? 55 : 65;
      default: return 0;
    endcase
  endfunction

  function automatic int lamp_phase(input int d);
    int n;
    n = int'(G[d]) + int'(Y[d]) + int'(L[d]) + int'(R[d]);
    if (n != 1) return 0;
    if (G[d]) return 1;
    if (Y[d]) return 2;
    if (L[d]) return 3;
    return 4;
  endfunction

  function automatic int ew_ph(input int s);
    if (s < 40) return 1;
    if (s < 45) return 2;
    if (s < 60) return 3;
    if (s < 65) return 2;
    return 4;
  endfunction

  function automatic int ns_ph(input int s);
    if (s < 65) return 4;
    if (s < 95) return 1;
    if (s < 100) return 2;
    if (s < 115) return 3;
    return 2;
  endfunction

  function automatic int pack(input int val, input int v, input int e);
    return ((val / 10) << 6) | ((val % 10) << 2) | (v << 1) | e;
  endfunction

`ifdef SEG7_EN
  function automatic int seg_of(input int dg);
    case (dg)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 0;
    endcase
  endfunction
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic expect_d(input string nm, input int d, input int val, input int v, input int e);
    logic [31:0] got;
    got = d ? {22'd0, ew_tens, ew_ones, ew_valid, ew_err} : {22'd0, ns_tens, ns_ones, ns_valid, ns_err};
    chk(nm, got, pack(val, v, e));
  endtask

  // Model: remaining = duration - ticks seen since the phase started, floored at 0.
  int m_ph[2], m_tk[2], e_rem[2], e_v[2], e_e[2];
  bit known = 1'b0;
  bit chk_now;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || m_ph[d] == 0) begin
        e_rem[d] = 0; e_v[d] = 0; e_e[d] = 0;
      end else begin
        e_v[d]   = 1;
        e_e[d]   = (m_tk[d] >= dur(d, m_ph[d])) ? 1 : 0;
        e_rem[d] = e_e[d] ? 0 : dur(d, m_ph[d]) - m_tk[d];
      end
    end
    for (int d = 0; d < 2; d++) begin
      int p;
      p = lamp_phase(d);
      if (rst) begin
        m_ph[d] = 0; m_tk[d] = 0;
      end else begin
        if (p == 0 || p != m_ph[d]) m_tk[d] = 0;
        else if (tick && m_tk[d] < 1000) m_tk[d]++;
        m_ph[d] = p;
      end
    end
    chk_now = known || rst;
    if (rst) known = 1'b1;
    #1;
    if (chk_now) begin
      expect_d("model_ew", 1, e_rem[1], e_v[1], e_e[1]);
      expect_d("model_ns", 0, e_rem[0], e_v[0], e_e[0]);
`ifdef SEG7_EN
      chk("model_ew_seg_t", ew_seg_t, (e_v[1] && e_rem[1] >= 10) ? seg_of(e_rem[1] / 10) : 0);
      chk("model_ew_seg_o", ew_seg_o, e_v[1] ? seg_of(e_rem[1] % 10) : 0);
      chk("model_ns_seg_t", ns_seg_t, (e_v[0] && e_rem[0] >= 10) ? seg_of(e_rem[0] / 10) : 0);
      chk("model_ns_seg_o", ns_seg_o, e_v[0] ? seg_of(e_rem[0] % 10) : 0);
`endif
    end
  end

  task automatic set_lamp(input int d, input int p);
    G[d] = (p == 1); Y[d] = (p == 2); L[d] = (p == 3); R[d] = (p == 4);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; G = '0; Y = '0; R = '0; L = '0;
    set_lamp(1, ew_ph(0)); set_lamp(0, ns_ph(0));
    repeat (3) @(negedge clk);
    expect_d("rst_ew", 1, 0, 0, 0);
    expect_d("rst_ns", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_d("release_ew40", 1, 40, 1, 0);
    expect_d("release_ns65", 0, 65, 1, 0);

    // Full controller cycle; lamp changes coincide with the tick that ends a phase.
    for (int s = 1; s <= 120; s++) begin
      set_lamp(1, ew_ph(s % 120)); set_lamp(0, ns_ph(s % 120));
      do_tick();
      if (s == 10)  begin expect_d("t10_ew30", 1, 30, 1, 0); expect_d("t10_ns55", 0, 55, 1, 0); end
      if (s == 40)  begin expect_d("g2y_ew05", 1, 5, 1, 0);  expect_d("g2y_ns25", 0, 25, 1, 0); end
      if (s == 64)  expect_d("t64_ew01", 1, 1, 1, 0);
      if (s == 65)  begin expect_d("t65_ew55", 1, 55, 1, 0); expect_d("t65_ns30", 0, 30, 1, 0); end
      if (s == 120) begin expect_d("wrap_ew40", 1, 40, 1, 0); expect_d("wrap_ns65", 0, 65, 1, 0); end
    end

    // Yellow held too long: expires to 00 with err, next phase clears it.
    set_lamp(1, 2);
    repeat (3) @(negedge clk);
    expect_d("hold_y_ew05", 1, 5, 1, 0);
    repeat (4) do_tick();
    expect_d("hold_y_ew01", 1, 1, 1, 0);
    do_tick();
    expect_d("expire_ew00_err", 1, 0, 1, 1);
    repeat (2) do_tick();
    expect_d("expire_hold_err", 1, 0, 1, 1);
    set_lamp(1, 3);
    repeat (3) @(negedge clk);
    expect_d("left_ew15_clr", 1, 15, 1, 0);
    repeat (8) do_tick();
    expect_d("left_ew07", 1, 7, 1, 0);
`ifdef SEG7_EN
    chk("seg7_ew07_t", ew_seg_t, 7'b0000000);
    chk("seg7_ew07_o", ew_seg_o, 7'b0000111);
`endif

    // Two lamps at once is illegal: display off, digits 00.
    set_lamp(1, 2);
    G[1] = 1'b1;
    repeat (3) @(negedge clk);
    expect_d("gy_ew_invalid", 1, 0, 0, 0);
    G[1] = 1'b0;
    repeat (3) @(negedge clk);
    expect_d("y_restore_ew05", 1, 5, 1, 0);

    // Reset mid-count, then reload from the lamps already present.
    set_lamp(1, 1);
    repeat (3) @(negedge clk);
    repeat (17) do_tick();
    expect_d("mid_ew23", 1, 23, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    expect_d("midrst_ew00", 1, 0, 0, 0);
    expect_d("midrst_ns00", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_d("postrst_ew40", 1, 40, 1, 0);
    expect_d("postrst_ns65", 0, 65, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
